// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared types, widths and address slicing for the data cache
//
// Contents: state_t (controller FSM states), OFFSET_W / LINE_W, and helpers that
// split a 32-bit byte address into tag, index and word fields. The index and tag
// helpers take the index width so that they serve any NUM_LINES.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        ALLOCATE
    } state_t;

    localparam int OFFSET_W = 5;
    localparam int LINE_W   = 256;

    function automatic logic [31:0] addr_index(input logic [31:0] addr, input int index_w);
        return (addr >> OFFSET_W) & ((32'd1 << index_w) - 32'd1);
    endfunction

    function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int index_w);
        return addr >> (OFFSET_W + index_w);
    endfunction

    function automatic logic [2:0] addr_word(input logic [31:0] addr);
        return 3'(addr >> 2);
    endfunction

endpackage

// File: rtl/dcache_sram.sv
// rtl/dcache_sram.sv - tag/valid/dirty and line data arrays of the data cache
//
// Ports:
//   clk_i, rst_i          clock; async active-high reset clears valid and dirty only
//   rd_index              combinational read port index
//   rd_valid/rd_dirty/rd_tag/rd_data   read port outputs
//   wr_index              synchronous write port index
//   wr_*_en / wr_*        per-field write enables and write values
module dcache_sram
    import dcache_pkg::*;
#(
    parameter  int NUM_LINES = 32,
    localparam int INDEX_W   = $clog2(NUM_LINES),
    localparam int TAG_W     = 32 - OFFSET_W - INDEX_W
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [INDEX_W-1:0] rd_index,
    output logic               rd_valid,
    output logic               rd_dirty,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [LINE_W-1:0]  rd_data,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic               wr_valid_en,
    input  logic               wr_valid,
    input  logic               wr_dirty_en,
    input  logic               wr_dirty,
    input  logic               wr_tag_en,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic               wr_data_en,
    input  logic [LINE_W-1:0]  wr_data
);

    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [LINE_W-1:0]    data_q [NUM_LINES];

    assign rd_valid = valid_q[rd_index];
    assign rd_dirty = dirty_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_data  = data_q[rd_index];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            if (wr_valid_en) valid_q[wr_index] <= wr_valid;
            if (wr_dirty_en) dirty_q[wr_index] <= wr_dirty;
        end
    end

    // Tag and data contents are meaningless until valid is set, so no reset.
    always_ff @(posedge clk_i) begin
        if (wr_tag_en)  tag_q[wr_index]  <= wr_tag;
        if (wr_data_en) data_q[wr_index] <= wr_data;
    end

endmodule

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped write-back write-allocate data cache controller
//
// Ports:
//   clk_i, rst_i                  clock; async active-high reset
//   p_addr_i, p_data_i            CPU byte address and store data
//   p_MemRead_i, p_MemWrite_i     load / store request (store wins)
//   p_data_o, p_stall_o           load data on hit; pipeline freeze
//   mem_enable_o, mem_write_o     block transaction request and direction
//   mem_addr_o, mem_data_o        block address and write-back line
//   mem_data_i, mem_ack_i         refill line and one-cycle completion pulse
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter  int NUM_LINES = 32,
    localparam int INDEX_W   = $clog2(NUM_LINES),
    localparam int TAG_W     = 32 - OFFSET_W - INDEX_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [31:0]       p_addr_i,
    input  logic [31:0]       p_data_i,
    input  logic              p_MemRead_i,
    input  logic              p_MemWrite_i,
    output logic [31:0]       p_data_o,
    output logic              p_stall_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [31:0]       mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i
);

    state_t state_q, state_d;

    logic [INDEX_W-1:0] req_index;
    logic [TAG_W-1:0]   req_tag;
    logic [2:0]         req_word;
    logic               req, hit, idle_hit;

    logic               rd_valid, rd_dirty;
    logic [TAG_W-1:0]   rd_tag;
    logic [LINE_W-1:0]  rd_data;

    logic               wr_valid_en, wr_valid, wr_dirty_en, wr_dirty, wr_tag_en, wr_data_en;
    logic [LINE_W-1:0]  wr_line;

    logic               en_d, wr_d;
    logic [31:0]        addr_d;
    logic [LINE_W-1:0]  data_d;

    // The pipeline is frozen while stalled, so the live address stays stable
    // and doubles as the victim/refill index for the whole miss sequence.
    assign req_index = INDEX_W'(addr_index(p_addr_i, INDEX_W));
    assign req_tag   = TAG_W'(addr_tag(p_addr_i, INDEX_W));
    assign req_word  = addr_word(p_addr_i);

    assign req      = p_MemRead_i | p_MemWrite_i;
    assign hit      = req && rd_valid && (rd_tag == req_tag);
    assign idle_hit = (state_q == IDLE) && hit;

    assign p_stall_o = req && !idle_hit;
    assign p_data_o  = idle_hit ? rd_data[{req_word, 5'b0} +: 32] : 32'd0;

    dcache_sram #(.NUM_LINES(NUM_LINES)) u_sram (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .rd_index    (req_index),
        .rd_valid    (rd_valid),
        .rd_dirty    (rd_dirty),
        .rd_tag      (rd_tag),
        .rd_data     (rd_data),
        .wr_index    (req_index),
        .wr_valid_en (wr_valid_en),
        .wr_valid    (wr_valid),
        .wr_dirty_en (wr_dirty_en),
        .wr_dirty    (wr_dirty),
        .wr_tag_en   (wr_tag_en),
        .wr_tag      (req_tag),
        .wr_data_en  (wr_data_en),
        .wr_data     (wr_line)
    );

    // Memory-side outputs are registers loaded on state entry, so they stay
    // constant through the transaction and never depend on mem_ack_i directly.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
            mem_addr_o   <= '0;
            mem_data_o   <= '0;
        end else begin
            state_q      <= state_d;
            mem_enable_o <= en_d;
            mem_write_o  <= wr_d;
            mem_addr_o   <= addr_d;
            mem_data_o   <= data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        en_d        = mem_enable_o;
        wr_d        = mem_write_o;
        addr_d      = mem_addr_o;
        data_d      = mem_data_o;
        wr_valid_en = 1'b0;
        wr_valid    = 1'b0;
        wr_dirty_en = 1'b0;
        wr_dirty    = 1'b0;
        wr_tag_en   = 1'b0;
        wr_data_en  = 1'b0;
        wr_line     = rd_data;
        wr_line[{req_word, 5'b0} +: 32] = p_data_i;

        case (state_q)
            IDLE: begin
                if (req && !hit) begin
                    en_d = 1'b1;
                    if (rd_valid && rd_dirty) begin
                        state_d = WRITEBACK;
                        wr_d    = 1'b1;
                        addr_d  = {rd_tag, req_index, 5'b0};
                        data_d  = rd_data;
                    end else begin
                        state_d = ALLOCATE;
                        wr_d    = 1'b0;
                        addr_d  = {req_tag, req_index, 5'b0};
                    end
                end else if (p_MemWrite_i && hit) begin
                    wr_data_en  = 1'b1;
                    wr_dirty_en = 1'b1;
                    wr_dirty    = 1'b1;
                end
            end
            WRITEBACK: begin
                if (mem_ack_i) begin
                    state_d     = ALLOCATE;
                    wr_d        = 1'b0;
                    addr_d      = {req_tag, req_index, 5'b0};
                    wr_dirty_en = 1'b1;
                end
            end
            ALLOCATE: begin
                if (mem_ack_i) begin
                    state_d     = IDLE;
                    en_d        = 1'b0;
                    wr_line     = mem_data_i;
                    wr_data_en  = 1'b1;
                    wr_tag_en   = 1'b1;
                    wr_valid_en = 1'b1;
                    wr_valid    = 1'b1;
                    wr_dirty_en = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - self-checking bench for dcache_ctrl against a behavioural cache model
module tb_dcache_ctrl;

    localparam int NUM_LINES = 32;
    localparam int LAT       = 10;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic [31:0]  p_addr_i, p_data_i;
    logic         p_MemRead_i, p_MemWrite_i;
    logic [31:0]  p_data_o;
    logic         p_stall_o;
    logic         mem_enable_o, mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic [255:0] mem_data_i;
    logic         model_ack = 1'b0;
    logic         stray_ack;
    logic         mem_ack_i;

    assign mem_ack_i = model_ack | stray_ack;

    always #5 clk_i = ~clk_i;

    dcache_ctrl #(.NUM_LINES(NUM_LINES)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .p_addr_i     (p_addr_i),
        .p_data_i     (p_data_i),
        .p_MemRead_i  (p_MemRead_i),
        .p_MemWrite_i (p_MemWrite_i),
        .p_data_o     (p_data_o),
        .p_stall_o    (p_stall_o),
        .mem_enable_o (mem_enable_o),
        .mem_write_o  (mem_write_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .mem_data_i   (mem_data_i),
        .mem_ack_i    (mem_ack_i)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic expect_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0000;
    endfunction

    // ---------------- off-chip memory model (10-cycle latency) ----------------
    typedef struct {
        logic         wr;
        logic [31:0]  addr;
        logic [255:0] data;
    } txn_t;

    logic [255:0] mem_blk [logic [31:0]];
    txn_t         txn_log [$];
    int           busy = 0;
    int           cnt  = 0;
    logic [31:0]  st_addr;
    logic         st_wr;

    function automatic logic [255:0] read_blk(input logic [31:0] ba);
        logic [255:0] b;
        if (mem_blk.exists(ba)) return mem_blk[ba];
        for (int k = 0; k < 8; k++) b[32*k +: 32] = init_word(ba + 32'(4*k));
        return b;
    endfunction

    // After each ack the memory spends one cycle idle before accepting the
    // next request, so back-to-back write-back/refill costs one extra cycle.
    always @(posedge clk_i) begin
        #1;
        mem_data_i = {8{$urandom}};
        if (rst_i) begin
            busy = 0;
            model_ack = 1'b0;
        end else if (model_ack) begin
            model_ack = 1'b0;
            busy = 0;
        end else if (!mem_enable_o) begin
            busy = 0;
        end else begin
            if (busy == 0) begin
                busy = 1;
                cnt = 1;
                st_addr = mem_addr_o;
                st_wr = mem_write_o;
            end else begin
                cnt++;
            end
            if (cnt == LAT) begin
                model_ack = 1'b1;
                expect_eq("mem_addr_stable", 256'(mem_addr_o), 256'(st_addr));
                expect_eq("mem_write_stable", 256'(mem_write_o), 256'(st_wr));
                if (mem_write_o) begin
                    mem_blk[mem_addr_o] = mem_data_o;
                    txn_log.push_back('{1'b1, mem_addr_o, mem_data_o});
                end else begin
                    mem_data_i = read_blk(mem_addr_o);
                    txn_log.push_back('{1'b0, mem_addr_o, mem_data_i});
                end
            end
        end
    end

    // ---------------- behavioural reference: cache state plus backing words ----------------
    logic [31:0] ref_words [logic [31:0]];
    bit          ref_valid [NUM_LINES];
    bit          ref_dirty [NUM_LINES];
    logic [31:0] ref_blk   [NUM_LINES];
    logic [31:0] ref_line  [NUM_LINES][8];

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        if (ref_words.exists(a)) return ref_words[a];
        return init_word(a);
    endfunction

    task automatic ref_reset();
        for (int i = 0; i < NUM_LINES; i++) begin
            ref_valid[i] = 1'b0;
            ref_dirty[i] = 1'b0;
        end
    endtask

    task automatic access(input bit is_wr, input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0]  ba, exp_data;
        logic [255:0] blk;
        int           idx, w, stalls, exp_stalls, n;
        bit           ref_hit;
        txn_t         exp_q [$];

        ba  = addr & 32'hFFFF_FFE0;
        idx = int'((addr >> 5) % NUM_LINES);
        w   = int'((addr >> 2) & 32'd7);
        ref_hit = ref_valid[idx] && (ref_blk[idx] == ba);
        exp_stalls = 0;
        if (!ref_hit) begin
            if (ref_valid[idx] && ref_dirty[idx]) begin
                for (int k = 0; k < 8; k++) begin
                    blk[32*k +: 32] = ref_line[idx][k];
                    ref_words[ref_blk[idx] + 32'(4*k)] = ref_line[idx][k];
                end
                exp_q.push_back('{1'b1, ref_blk[idx], blk});
                exp_stalls = 2 * LAT + 2;
            end else begin
                exp_stalls = LAT + 1;
            end
            for (int k = 0; k < 8; k++) begin
                ref_line[idx][k] = ref_word(ba + 32'(4*k));
                blk[32*k +: 32] = ref_line[idx][k];
            end
            exp_q.push_back('{1'b0, ba, blk});
            ref_valid[idx] = 1'b1;
            ref_blk[idx]   = ba;
            ref_dirty[idx] = 1'b0;
        end
        if (is_wr) begin
            ref_line[idx][w] = wdata;
            ref_dirty[idx]   = 1'b1;
        end
        exp_data = ref_line[idx][w];

        @(posedge clk_i);
        #1;
        txn_log.delete();
        p_addr_i     = addr;
        p_data_i     = wdata;
        p_MemWrite_i = is_wr;
        p_MemRead_i  = is_wr ? 1'($urandom_range(0, 1)) : 1'b1;
        stalls = 0;
        @(negedge clk_i);
        while (p_stall_o && stalls < 100) begin
            stalls++;
            @(negedge clk_i);
        end
        expect_eq("stall_cycles", 256'(stalls), 256'(exp_stalls));
        if (!is_wr) expect_eq("load_data", 256'(p_data_o), 256'(exp_data));
        @(posedge clk_i);
        #1;
        p_MemRead_i  = 1'b0;
        p_MemWrite_i = 1'b0;
        p_addr_i     = $urandom;
        p_data_i     = $urandom;

        expect_eq("txn_count", 256'(txn_log.size()), 256'(exp_q.size()));
        n = (txn_log.size() < exp_q.size()) ? txn_log.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            expect_eq("txn_write", 256'(txn_log[i].wr), 256'(exp_q[i].wr));
            expect_eq("txn_addr", 256'(txn_log[i].addr), 256'(exp_q[i].addr));
            expect_eq("txn_data", txn_log[i].data, exp_q[i].data);
        end
    endtask

    // ---------------- stimulus ----------------
    logic [255:0] b40;
    logic [31:0]  ra;
    bit           rw;

    initial begin
        rst_i        = 1'b1;
        p_addr_i     = 32'h0;
        p_data_i     = 32'h0;
        p_MemRead_i  = 1'b0;
        p_MemWrite_i = 1'b0;
        stray_ack    = 1'b0;
        ref_reset();
        ref_words[32'h40] = 32'hDEAD_BEEF;
        b40 = read_blk(32'h40);
        b40[31:0] = 32'hDEAD_BEEF;
        mem_blk[32'h40] = b40;

        #2;
        expect_eq("rst_stall", 256'(p_stall_o), 256'(0));
        expect_eq("rst_enable", 256'(mem_enable_o), 256'(0));
        expect_eq("rst_write", 256'(mem_write_o), 256'(0));
        expect_eq("rst_addr", 256'(mem_addr_o), 256'(0));
        expect_eq("rst_wdata", mem_data_o, 256'(0));
        expect_eq("rst_pdata", 256'(p_data_o), 256'(0));
        p_MemRead_i = 1'b1;
        p_addr_i    = 32'h40;
        #1;
        expect_eq("rst_stall_req", 256'(p_stall_o), 256'(1));
        expect_eq("rst_pdata_req", 256'(p_data_o), 256'(0));
        p_MemRead_i = 1'b0;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        access(1'b0, 32'h0000_0040, 32'h0);
        access(1'b1, 32'h0000_0044, 32'h1234_5678);
        access(1'b0, 32'h0000_0044, 32'h0);
        access(1'b0, 32'h0000_0440, 32'h0);
        access(1'b1, 32'h0000_0080, 32'hCAFE_F00D);
        access(1'b0, 32'h0000_0480, 32'h0);

        @(posedge clk_i);
        #1;
        stray_ack = 1'b1;
        @(negedge clk_i);
        expect_eq("stray_stall", 256'(p_stall_o), 256'(0));
        expect_eq("stray_enable", 256'(mem_enable_o), 256'(0));
        @(posedge clk_i);
        #1;
        stray_ack = 1'b0;
        access(1'b0, 32'h0000_0480, 32'h0);

        // Reset while a refill is outstanding.
        @(posedge clk_i);
        #1;
        p_addr_i    = 32'h0000_09A0;
        p_MemRead_i = 1'b1;
        repeat (3) @(negedge clk_i);
        expect_eq("alloc_enable", 256'(mem_enable_o), 256'(1));
        expect_eq("alloc_write", 256'(mem_write_o), 256'(0));
        rst_i = 1'b1;
        #1;
        expect_eq("midrst_enable", 256'(mem_enable_o), 256'(0));
        expect_eq("midrst_stall", 256'(p_stall_o), 256'(1));
        p_MemRead_i = 1'b0;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        ref_reset();
        access(1'b0, 32'h0000_09A0, 32'h0);
        access(1'b0, 32'h0000_0044, 32'h0);

        for (int i = 0; i < 150; i++) begin
            ra = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 3)) << 5)
               | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
            rw = 1'($urandom_range(0, 1));
            access(rw, ra, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Direct-mapped, write-back, write-allocate data cache between the CPU's MEM stage and a slow, block-wide off-chip data memory. On a hit it serves loads and stores with zero stall. On a miss it raises a stall that freezes the whole pipeline, writes back a dirty victim if needed, refills the line, then resolves the access.

## Interface
Parameters:
- NUM_LINES, 32: number of cache lines; power of two, ≥2.
- Derived, not overridable: OFFSET_W=5 (32-byte line), INDEX_W=log2(NUM_LINES), TAG_W=32-OFFSET_W-INDEX_W.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset; asynchronous, active-high.
- p_addr_i  in  32  byte address from EX_MEM ALU result; bits [1:0] ignored.
- p_data_i  in  32  store data.
- p_MemRead_i  in  1  load request.
- p_MemWrite_i  in  1  store request; wins if asserted together with p_MemRead_i.
- p_data_o  out  32  load data, valid when request active and p_stall_o=0.
- p_stall_o  out  1  freezes PC, IF_ID, ID_EX, EX_MEM and MEM_WB.
- mem_enable_o  out  1  memory transaction request.
- mem_write_o  out  1  1=block write, 0=block read.
- mem_addr_o  out  32  block-aligned address, [4:0]=0.
- mem_data_o  out  256  write-back block.
- mem_data_i  in  256  refill block.
- mem_ack_i  in  1  one-cycle pulse completing the current transaction.

## Operation
- Address split: tag=[31:OFFSET_W+INDEX_W], index=[OFFSET_W+INDEX_W-1:OFFSET_W], word=[4:2].
- Per line: valid, dirty, tag, 256-bit data. Word w occupies data[32w+31:32w].
- hit = req & valid[index] & (tag[index]==addr tag), where req = p_MemRead_i | p_MemWrite_i.
- FSM states: IDLE, WRITEBACK, ALLOCATE.
- IDLE:
  - Read hit: p_data_o = selected word, combinationally.
  - Write hit: at the clock edge, the word is replaced and dirty is set.
  - Miss with victim valid & dirty: go to WRITEBACK.
  - Miss otherwise: go to ALLOCATE.
  - No request: stay in IDLE.
- WRITEBACK:
  - mem_enable_o=1, mem_write_o=1.
  - mem_addr_o={victim tag, index, 5'b0}.
  - mem_data_o=victim line.
  - On mem_ack_i: dirty cleared, go to ALLOCATE.
- ALLOCATE:
  - mem_enable_o=1, mem_write_o=0.
  - mem_addr_o={req tag, index, 5'b0}.
  - On mem_ack_i: line data=mem_data_i, tag=req tag, valid=1, dirty=0; go to IDLE.
  - The access then hits in IDLE and is performed there. A store sets dirty at that point.
- Request changes are impossible while stalled, because the pipeline is frozen. The controller reads p_addr_i live, not latched.
- mem_ack_i outside WRITEBACK/ALLOCATE is ignored.
- p_stall_o = req & ~(state==IDLE & hit).
- Reset values:
  - state=IDLE, all valid=0, all dirty=0.
  - mem_enable_o=0, mem_write_o=0, mem_addr_o=0, mem_data_o=0.
  - p_data_o=0 when no hit. p_stall_o follows req: it is high if a request is present during reset.
  - Data and tag arrays are not reset.
- Reset mid-transaction: the transaction is abandoned immediately and the FSM returns to IDLE. The memory must tolerate mem_enable_o dropping before ack.

## Timing
- Hit: 0 stall cycles; load data valid in the request cycle; store committed at the end of that cycle.
- Clean miss, request cycle R:
  - Edge after R: FSM enters ALLOCATE.
  - Ack in cycle A: line refilled at the end of A.
  - p_stall_o high for R..A, low in A+1, where the access completes.
- Dirty miss:
  - WRITEBACK runs from R+1 until ack W.
  - ALLOCATE runs from W+1 until ack A.
  - Stall high for R..A.
- Memory outputs (enable, write, addr, data) are held stable from state entry until ack, inclusive.
- All memory-side outputs are driven from state and arrays only, with no combinational path from mem_ack_i.

## Structure
- Package dcache_pkg holds:
  - state enum {IDLE, WRITEBACK, ALLOCATE};
  - OFFSET_W, LINE_W=256;
  - address-field slicing functions.
- Sub-module dcache_sram (parameter NUM_LINES) holds the tag/valid/dirty and data arrays.
  - One read port, combinational.
  - One write port, synchronous, with per-field enables.
  - Valid/dirty cleared by rst_i.
- dcache_ctrl itself contains the FSM, hit logic, word merge/select and memory-side registers.

## Test plan
Bench memory model: 10-cycle fixed latency.
- Cold load from 0x0000_0040, memory word=0xDEAD_BEEF → stall 11 cycles (R..R+10); then p_data_o=0xDEAD_BEEF; one ALLOCATE read to 0x40.
- Store 0x1234_5678 to 0x44 after line 0x40 is filled → 0 stall; subsequent load 0x44 returns 0x1234_5678; no memory traffic.
- Load 0x440 (same index as 0x40 with NUM_LINES=32, dirty) → WRITEBACK to 0x40 whose block contains 0x1234_5678 in word 1; then ALLOCATE 0x440; stall 22 cycles.
- Store miss to clean line at 0x80 → ALLOCATE only; after completion dirty=1; evicting it later produces a write-back carrying the stored word.
- rst_i asserted during ALLOCATE → mem_enable_o=0 asynchronously; FSM in IDLE; repeat load of the same address misses again (valid=0).
- Stray mem_ack_i pulse in IDLE with no request → no state change, no array update, p_stall_o=0.
